// File: rtl/frame_bank_ctrl.sv
// frame_bank_ctrl: SDRAM frame-buffer bank manager between a camera writer and a display reader.
// Ports:
//   clk_ref          - SDRAM controller clock (single clock domain)
//   rst              - asynchronous active-high reset
//   sdram_init_done  - level, SDRAM initialisation complete
//   frame_valid      - level, high for the duration of each camera frame
//   frame_write_done - pulse, a full frame has been written to SDRAM
//   frame_read_done  - pulse, a full frame has been read from SDRAM
//   wr_bank/rd_bank  - SDRAM write/read bank (0..2, never 3)
//   wr_load/rd_load  - write/read address reset pulses, LOAD_CYCLES wide
//   wr_en            - sys_we gate, high only while an accepted frame is written
//   drop_cnt         - dropped-frame count, saturating at 255
// Build option: define TRIPLE_BUF_EN for three-bank triple buffering;
// leave it undefined for two-bank ping-pong with a hold state.
module frame_bank_ctrl #(
    parameter int LOAD_CYCLES = 4
) (
    input  logic       clk_ref,
    input  logic       rst,
    input  logic       sdram_init_done,
    input  logic       frame_valid,
    input  logic       frame_write_done,
    input  logic       frame_read_done,
    output logic [1:0] wr_bank,
    output logic [1:0] rd_bank,
    output logic       wr_load,
    output logic       rd_load,
    output logic       wr_en,
    output logic [7:0] drop_cnt
);
    typedef enum logic [2:0] {W_IDLE, W_ARM, W_WAIT, W_ACTIVE, W_HOLD} wstate_t;
    localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYCLES - 1);
    localparam logic [3:0] LOAD_LEN = 4'(LOAD_CYCLES);
`ifdef TRIPLE_BUF_EN
    localparam wstate_t AFTER_COMMIT = W_ARM;
`else
    localparam wstate_t AFTER_COMMIT = W_HOLD;
`endif
    wstate_t state;
    wstate_t state_nxt;
    logic fv_q;
    logic [3:0] wr_cnt;
    logic [3:0] rd_cnt;
    logic [1:0] latest;
    logic [1:0] rd_nxt;
    logic [1:0] wr_nxt;
    logic pending;
    logic rise;
    logic fall;
    logic commit;
    logic drop;
    assign rise = frame_valid & ~fv_q;
    assign fall = ~frame_valid & fv_q;
    assign commit = (state == W_ACTIVE) & frame_write_done;
    assign drop = (rise & ((state == W_ARM) | (state == W_HOLD)))
                | ((state == W_ACTIVE) & ~frame_write_done & fall);
    // Read update always sees the pre-commit latest/pending.
    assign rd_nxt = (frame_read_done & pending) ? latest : rd_bank;
`ifdef TRIPLE_BUF_EN
    // Banks are 0..2 and new rd_bank != new latest, so 3 - a - b is the remaining one.
    assign wr_nxt = commit ? 2'd3 - rd_nxt - wr_bank : wr_bank;
`else
    // Ping-pong: writer takes over the bank the reader just released.
    assign wr_nxt = ((state == W_HOLD) & frame_read_done) ? rd_bank : wr_bank;
`endif
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst)
            state <= W_IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            W_IDLE:   if (sdram_init_done) state_nxt = W_ARM;
            W_ARM:    if (wr_cnt == LOAD_LAST) state_nxt = W_WAIT;
            W_WAIT:   if (rise) state_nxt = W_ACTIVE;
            W_ACTIVE: state_nxt = frame_write_done ? AFTER_COMMIT : (fall ? W_ARM : W_ACTIVE);
            W_HOLD:   if (frame_read_done) state_nxt = W_ARM;
            default:  state_nxt = W_IDLE;
        endcase
    end
    always_comb begin
        wr_load = state == W_ARM;
        wr_en = state == W_ACTIVE;
    end
    assign rd_load = rd_cnt != 4'd0;
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            // Registered frame_valid resets high so a frame in flight at release is not a new edge.
            fv_q <= 1'b1;
            wr_cnt <= 4'd0;
            rd_cnt <= 4'd0;
            wr_bank <= 2'd0;
            rd_bank <= 2'd1;
            latest <= 2'd0;
            pending <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            fv_q <= frame_valid;
            wr_cnt <= (state == W_ARM) ? wr_cnt + 4'd1 : 4'd0;
            rd_cnt <= frame_read_done ? LOAD_LEN : ((rd_cnt != 4'd0) ? rd_cnt - 4'd1 : 4'd0);
            rd_bank <= rd_nxt;
            wr_bank <= wr_nxt;
            latest <= commit ? wr_bank : latest;
            pending <= commit | (pending & ~frame_read_done);
            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_frame_bank_ctrl.sv
// tb_frame_bank_ctrl: vector-table and scoreboard bench for frame_bank_ctrl.
module tb_frame_bank_ctrl;
    logic clk_ref = 1'b0;
    logic rst = 1'b1;
    logic sdram_init_done = 1'b0;
    logic frame_valid = 1'b0;
    logic frame_write_done = 1'b0;
    logic frame_read_done = 1'b0;
    logic [1:0] wr_bank;
    logic [1:0] rd_bank;
    logic wr_load;
    logic rd_load;
    logic wr_en;
    logic [7:0] drop_cnt;
    int n_vec = 0;
    int n_bad = 0;
    typedef struct {
        logic init, fv, wd, rd;
        logic [1:0] wb, rb;
        logic wl, rl, we;
        logic [7:0] dc;
    } vec_t;
    vec_t tbl[$];
    vec_t sb[$];
    frame_bank_ctrl #(.LOAD_CYCLES(4)) dut (
        .clk_ref(clk_ref),
        .rst(rst),
        .sdram_init_done(sdram_init_done),
        .frame_valid(frame_valid),
        .frame_write_done(frame_write_done),
        .frame_read_done(frame_read_done),
        .wr_bank(wr_bank),
        .rd_bank(rd_bank),
        .wr_load(wr_load),
        .rd_load(rd_load),
        .wr_en(wr_en),
        .drop_cnt(drop_cnt)
    );
    always #5 clk_ref = ~clk_ref;
    task automatic v(input logic init, fv, wd, rd, input logic [1:0] wb, rb,
                     input logic wl, rl, we, input logic [7:0] dc);
        vec_t t;
        t.init = init;
        t.fv = fv;
        t.wd = wd;
        t.rd = rd;
        t.wb = wb;
        t.rb = rb;
        t.wl = wl;
        t.rl = rl;
        t.we = we;
        t.dc = dc;
        tbl.push_back(t);
    endtask
    task automatic apply(input vec_t t, input int idx);
        vec_t e;
        sdram_init_done = t.init;
        frame_valid = t.fv;
        frame_write_done = t.wd;
        frame_read_done = t.rd;
        sb.push_back(t);
        @(posedge clk_ref);
        #1;
        e = sb.pop_front();
        n_vec++;
        if ({wr_bank, rd_bank, wr_load, rd_load, wr_en, drop_cnt} !==
            {e.wb, e.rb, e.wl, e.rl, e.we, e.dc}) begin
            n_bad++;
            $display("FAIL vec%0d: got wb=%0d rb=%0d wl=%0d rl=%0d we=%0d dc=%0d, want wb=%0d rb=%0d wl=%0d rl=%0d we=%0d dc=%0d",
                     idx, wr_bank, rd_bank, wr_load, rd_load, wr_en, drop_cnt,
                     e.wb, e.rb, e.wl, e.rl, e.we, e.dc);
        end
    endtask
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask
    task automatic step();
        @(posedge clk_ref);
        #1;
    endtask
    task automatic check_reset_values(input string tag);
        check({tag, "_wr_bank"}, 32'(wr_bank), 0);
        check({tag, "_rd_bank"}, 32'(rd_bank), 1);
        check({tag, "_wr_load"}, 32'(wr_load), 0);
        check({tag, "_rd_load"}, 32'(rd_load), 0);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
    endtask
    initial begin
        logic [7:0] prev;
        bit wrapped;
        wrapped = 0;
        repeat (3) step();
        check_reset_values("reset");
        // Columns: init fv wd rd | wr_bank rd_bank wr_load rd_load wr_en drop_cnt (after the edge)
        v(0,0,0,0, 0,1, 0,0,0, 0);
        v(1,0,0,0, 0,1, 1,0,0, 0);
        for (int i = 0; i < 3; i++) v(1,0,0,0, 0,1, 1,0,0, 0);
        v(1,0,0,0, 0,1, 0,0,0, 0);
        v(1,1,0,0, 0,1, 0,0,1, 0);
        v(1,1,0,0, 0,1, 0,0,1, 0);
`ifdef TRIPLE_BUF_EN
        v(1,1,1,0, 2,1, 1,0,0, 0);
        for (int i = 0; i < 3; i++) v(1,1,0,0, 2,1, 1,0,0, 0);
        v(1,1,0,0, 2,1, 0,0,0, 0);
        v(1,0,0,0, 2,1, 0,0,0, 0);
        v(1,1,0,0, 2,1, 0,0,1, 0);
        v(1,1,1,1, 1,0, 1,1,0, 0);
        v(1,1,0,1, 1,2, 1,1,0, 0);
        v(1,0,0,0, 1,2, 1,1,0, 0);
        v(1,1,0,0, 1,2, 1,1,0, 1);
        v(1,1,0,0, 1,2, 0,1,0, 1);
        v(1,1,0,1, 1,2, 0,1,0, 1);
        v(1,0,0,0, 1,2, 0,1,0, 1);
        v(1,1,0,0, 1,2, 0,1,1, 1);
        v(1,0,0,0, 1,2, 1,1,0, 2);
        v(1,0,0,0, 1,2, 1,0,0, 2);
`else
        v(1,1,1,0, 0,1, 0,0,0, 0);
        v(1,0,0,0, 0,1, 0,0,0, 0);
        v(1,1,0,0, 0,1, 0,0,0, 1);
        v(1,1,0,1, 1,0, 1,1,0, 1);
        v(1,1,0,0, 1,0, 1,1,0, 1);
        v(1,0,0,0, 1,0, 1,1,0, 1);
        v(1,0,0,0, 1,0, 1,1,0, 1);
        v(1,0,0,0, 1,0, 0,0,0, 1);
        v(1,1,0,0, 1,0, 0,0,1, 1);
        v(1,0,0,0, 1,0, 1,0,0, 2);
        v(1,0,1,0, 1,0, 1,0,0, 2);
        v(1,0,0,0, 1,0, 1,0,0, 2);
        v(1,0,0,1, 1,0, 1,1,0, 2);
        v(1,0,0,1, 1,0, 0,1,0, 2);
        for (int i = 0; i < 3; i++) v(1,0,0,0, 1,0, 0,1,0, 2);
        v(1,0,0,0, 1,0, 0,0,0, 2);
        v(0,1,0,0, 1,0, 0,0,1, 2);
        v(0,1,1,1, 1,0, 0,1,0, 2);
        v(0,0,0,0, 1,0, 0,1,0, 2);
        v(0,1,0,0, 1,0, 0,1,0, 3);
        v(0,1,0,0, 1,0, 0,1,0, 3);
        v(0,1,0,0, 1,0, 0,0,0, 3);
        v(0,1,0,1, 0,1, 1,1,0, 3);
        for (int i = 0; i < 3; i++) v(0,1,0,0, 0,1, 1,1,0, 3);
        v(0,1,0,0, 0,1, 0,0,0, 3);
        v(0,0,0,0, 0,1, 0,0,0, 3);
        v(0,1,0,0, 0,1, 0,0,1, 3);
`endif
        rst = 1'b0;
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
        // Toggle frame_valid every cycle to force several hundred drops.
        sdram_init_done = 1'b1;
        frame_write_done = 1'b0;
        frame_read_done = 1'b0;
        prev = drop_cnt;
        for (int i = 0; i < 2000; i++) begin
            frame_valid = ~frame_valid;
            step();
            if (drop_cnt < prev) wrapped = 1;
            prev = drop_cnt;
        end
        check("drop_saturated", 32'(drop_cnt), 255);
        check("drop_never_wrapped", 32'(wrapped), 0);
        frame_valid = 1'b0;
        repeat (8) step();
        frame_valid = 1'b1;
        step();
        check("active_before_rst", 32'(wr_en), 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        step();
        rst = 1'b0;
        repeat (6) step();
        check("no_edge_at_release_wr_en", 32'(wr_en), 0);
        check("no_edge_at_release_drop", 32'(drop_cnt), 0);
        check("no_edge_at_release_wr_load", 32'(wr_load), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/frame_bank_ctrl.md
FRAME_BANK_CTRL -- requirements
Module: frame_bank_ctrl

Interface
REQ-001 SHALL have parameter LOAD_CYCLES, default 4: width in clk_ref cycles of every wr_load/rd_load pulse, legal range 1..15.
REQ-002 SHALL have port clk_ref, input, 1 bit: the single clock, which is the SDRAM controller clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port sdram_init_done, input, 1 bit: level, SDRAM initialisation complete.
REQ-005 SHALL have port frame_valid, input, 1 bit: level, high for the duration of each camera frame, synchronous to clk_ref.
REQ-006 SHALL have port frame_write_done, input, 1 bit: one-cycle pulse, SDRAM write of a full frame finished.
REQ-007 SHALL have port frame_read_done, input, 1 bit: one-cycle pulse, SDRAM read of a full frame finished.
REQ-008 SHALL have port wr_bank, output, 2 bits: SDRAM write bank.
REQ-009 SHALL have port rd_bank, output, 2 bits: SDRAM read bank.
REQ-010 SHALL have port wr_load, output, 1 bit: write-address reset pulse.
REQ-011 SHALL have port rd_load, output, 1 bit: read-address reset pulse.
REQ-012 SHALL have port wr_en, output, 1 bit: gate for sys_we; high only while an accepted frame is being written.
REQ-013 SHALL have port drop_cnt, output, 8 bits: count of dropped camera frames, saturating at 255.

Function
REQ-014 Write FSM states SHALL be W_IDLE, W_ARM, W_WAIT, W_ACTIVE and W_HOLD.
REQ-015 W_IDLE SHALL go to W_ARM on the first cycle sdram_init_done=1.
REQ-016 W_ARM SHALL hold wr_load=1 for exactly LOAD_CYCLES cycles, then go to W_WAIT.
REQ-017 W_WAIT SHALL go to W_ACTIVE on a frame_valid rising edge (registered frame_valid 0 -> 1).
REQ-018 wr_en SHALL be 1 exactly while in W_ACTIVE, starting the cycle after the edge is detected.
REQ-019 A frame_valid rising edge seen in W_ARM or W_HOLD SHALL drop that frame: drop_cnt+1, and the frame is not written.
REQ-020 In W_ACTIVE, frame_write_done SHALL commit: latest<=wr_bank, pending<=1, wr_bank<=next bank, then go to W_ARM (or W_HOLD, see REQ-027).
REQ-021 In W_ACTIVE, a frame_valid falling edge without frame_write_done SHALL be a short frame: drop_cnt+1, no commit, same wr_bank, go to W_ARM.
REQ-022 frame_write_done outside W_ACTIVE SHALL be ignored.
REQ-023 Read side: frame_read_done SHALL start an rd_load pulse of LOAD_CYCLES cycles, beginning the next cycle.
REQ-024 On frame_read_done, if pending=1, the block SHALL set rd_bank<=latest and pending<=0; otherwise rd_bank is unchanged (the same frame repeats).
REQ-025 When frame_read_done and frame_write_done arrive in the same cycle, the read update SHALL use the pre-commit latest/pending; the commit is then applied and pending ends at 1.
REQ-026 frame_read_done arriving while rd_load is already high SHALL restart the pulse count.
REQ-027 Next write bank (TRIPLE_BUF_EN defined): the unique bank in {0,1,2} that differs from both the new rd_bank and the new latest; W_HOLD is never entered.
REQ-028 Next write bank (TRIPLE_BUF_EN undefined): after a commit, the FSM SHALL go to W_HOLD; on the next frame_read_done it SHALL take wr_bank<=the old rd_bank and go to W_ARM.
REQ-029 Bank 3 SHALL never appear on wr_bank or rd_bank.
REQ-030 wr_bank SHALL never equal rd_bank while wr_en=1.
REQ-031 drop_cnt SHALL saturate at 255 and never wrap.
REQ-032 sdram_init_done falling SHALL NOT affect the FSM; only rst returns it to W_IDLE.

Reset
REQ-033 While rst=1 the block SHALL hold: state W_IDLE, wr_bank=0, rd_bank=1, latest=0, pending=0, wr_load=0, rd_load=0, wr_en=0, drop_cnt=0.
REQ-034 The registered frame_valid SHALL reset to 1, so a frame already in progress at release is not treated as a rising edge.
REQ-035 A reset asserted mid-frame SHALL force wr_en=0 immediately (asynchronously).

Configuration
REQ-036 Macro TRIPLE_BUF_EN defined SHALL select three-bank triple buffering (REQ-027) with no hold-induced drops.
REQ-037 Macro TRIPLE_BUF_EN undefined SHALL select two-bank ping-pong (REQ-028); frames arriving in W_HOLD are dropped.

Verification
REQ-038 With TRIPLE_BUF_EN defined: release rst, sdram_init_done=1 -> wr_load high 4 cycles, wr_bank=0, rd_bank=1; frame_valid rise -> wr_en=1 one cycle later.
REQ-039 With TRIPLE_BUF_EN defined: frame_write_done pulse -> wr_bank=2, pending=1; then frame_read_done -> rd_bank=0, rd_load high 4 cycles.
REQ-040 With TRIPLE_BUF_EN defined: frame_write_done and frame_read_done in the same cycle, starting from wr_bank=2, latest=0, pending=1, rd_bank=1 -> rd_bank=0, latest=2, wr_bank=1, pending=1.
REQ-041 With TRIPLE_BUF_EN undefined: commit bank 0, then frame_valid rises before frame_read_done -> state W_HOLD, drop_cnt=1, wr_en stays 0; frame_read_done -> rd_bank=0, wr_bank=1, W_ARM.
REQ-042 frame_valid falls in W_ACTIVE without frame_write_done -> drop_cnt+1, wr_bank unchanged, wr_load pulses again.
REQ-043 300 dropped frames -> drop_cnt=255; rst asserted mid-W_ACTIVE -> wr_en=0 in the same cycle, all outputs at their reset values.
